store_checker: RTL and testbench

Synthesizable end-of-test store monitor for the four-issue pipeline. It watches every memory-stage store lane in parallel and returns a sticky pass/fail/timeout verdict with diagnostic capture. Pass is a store of PASS_DATA to PASS_ADDR. Stores to SCRATCH_ADDR are tolerated. Any other store is a failure. It sits beside `top`, on the store ports of the memory stage, and is shared by simulation benches and FPGA self-test.

---
 rtl/store_checker_if.sv | 20 ++
 rtl/store_checker.sv | 169 ++++++++++++++++
 tb/tb_store_checker.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_checker_if.sv
// ----------------------------------------------------------------------------
// store_checker_if
// Store-lane bundle from the memory stage into store_checker.
//   we     : per-lane store enable, lane 0 oldest
//   addr   : lane i at [i*AW +: AW]
//   wdata  : lane i at [i*DW +: DW]
// Modports: master (memory stage / bench drives), slave (checker observes).
// ----------------------------------------------------------------------------
interface store_checker_if #(
   parameter int unsigned NLANES = 4,
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32
);
   logic [NLANES-1:0]    we;
   logic [NLANES*AW-1:0] addr;
   logic [NLANES*DW-1:0] wdata;

   modport master (output we, addr, wdata);
   modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/store_checker.sv
// ----------------------------------------------------------------------------
// store_checker
// End-of-test store monitor. Watches all store lanes in parallel and latches
// a sticky pass / fail / timeout verdict with capture of the failing store.
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous restart, beats any store in the same cycle
//   st           : store lanes (store_checker_if.slave)
//   done         : pass | fail | timeout
//   pass/fail/timeout : sticky verdicts, decoded from state
//   store_count  : stores accepted up to and including the deciding store
//   cycle_count  : cycles spent in RUN, saturating
//   fail_lane/fail_addr/fail_data : capture of the failing store
// Build option: define STORE_CHECKER_TIMEOUT_EN to compile in the watchdog;
// otherwise timeout is tied low and TOUT does not exist.
// ----------------------------------------------------------------------------
module store_checker #(
   parameter int unsigned   NLANES       = 4,
   parameter int unsigned   AW           = 32,
   parameter int unsigned   DW           = 32,
   parameter logic [AW-1:0] PASS_ADDR    = 84,
   parameter logic [DW-1:0] PASS_DATA    = 7,
   parameter logic [AW-1:0] SCRATCH_ADDR = 80,
   parameter int unsigned   TIMEOUT      = 10000,
   parameter int unsigned   CW           = 32,
   localparam int unsigned  LW           = (NLANES > 1) ? $clog2(NLANES) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   store_checker_if.slave st,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          timeout,
   output logic [15:0]   store_count,
   output logic [CW-1:0] cycle_count,
   output logic [LW-1:0] fail_lane,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_data
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_PASS = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;
`ifdef STORE_CHECKER_TIMEOUT_EN
   localparam logic [1:0] ST_TOUT = 2'd3;
`endif

   logic [1:0]    state_q, state_d;
   logic [15:0]   store_count_q, store_count_d;
   logic [CW-1:0] cycle_count_q, cycle_count_d;
   logic [LW-1:0] fail_lane_q, fail_lane_d;
   logic [AW-1:0] fail_addr_q, fail_addr_d;
   logic [DW-1:0] fail_data_q, fail_data_d;

   // Result of the oldest-first lane scan for this cycle
   logic          dec_hit;
   logic          dec_pass;
   logic [LW-1:0] dec_lane;
   logic [AW-1:0] dec_addr;
   logic [DW-1:0] dec_data;
   logic [16:0]   lane_cnt;
   logic [AW-1:0] lane_addr;
   logic [DW-1:0] lane_data;
   logic [16:0]   count_sum;

   always_comb begin
      dec_hit   = 1'b0;
      dec_pass  = 1'b0;
      dec_lane  = '0;
      dec_addr  = '0;
      dec_data  = '0;
      lane_cnt  = '0;
      lane_addr = '0;
      lane_data = '0;
      for (int i = 0; i < NLANES; i++) begin
         lane_addr = st.addr[i*AW +: AW];
         lane_data = st.wdata[i*DW +: DW];
         // Once a lane decides, younger lanes are neither judged nor counted
         if (!dec_hit && st.we[i]) begin
            lane_cnt = lane_cnt + 17'd1;
            if (lane_addr == PASS_ADDR && lane_data == PASS_DATA) begin
               dec_hit  = 1'b1;
               dec_pass = 1'b1;
            end else if (lane_addr != SCRATCH_ADDR) begin
               dec_hit  = 1'b1;
               dec_lane = LW'(i);
               dec_addr = lane_addr;
               dec_data = lane_data;
            end
         end
      end
   end

   assign count_sum = {1'b0, store_count_q} + lane_cnt;

   always_comb begin
      state_d       = state_q;
      store_count_d = store_count_q;
      cycle_count_d = cycle_count_q;
      fail_lane_d   = fail_lane_q;
      fail_addr_d   = fail_addr_q;
      fail_data_d   = fail_data_q;
      if (clear) begin
         state_d       = ST_RUN;
         store_count_d = '0;
         cycle_count_d = '0;
         fail_lane_d   = '0;
         fail_addr_d   = '0;
         fail_data_d   = '0;
      end else if (state_q == ST_RUN) begin
         if (cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + CW'(1);
         end
         store_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
         if (dec_hit) begin
            if (dec_pass) begin
               state_d = ST_PASS;
            end else begin
               state_d     = ST_FAIL;
               fail_lane_d = dec_lane;
               fail_addr_d = dec_addr;
               fail_data_d = dec_data;
            end
         end
`ifdef STORE_CHECKER_TIMEOUT_EN
         // Lane verdict above takes precedence over the watchdog
         else if (cycle_count_q == CW'(TIMEOUT - 1)) begin
            state_d = ST_TOUT;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_RUN;
         store_count_q <= '0;
         cycle_count_q <= '0;
         fail_lane_q   <= '0;
         fail_addr_q   <= '0;
         fail_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         store_count_q <= store_count_d;
         cycle_count_q <= cycle_count_d;
         fail_lane_q   <= fail_lane_d;
         fail_addr_q   <= fail_addr_d;
         fail_data_q   <= fail_data_d;
      end
   end

   assign pass = (state_q == ST_PASS);
   assign fail = (state_q == ST_FAIL);
`ifdef STORE_CHECKER_TIMEOUT_EN
   assign timeout = (state_q == ST_TOUT);
`else
   assign timeout = 1'b0;
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif
   assign done        = pass | fail | timeout;
   assign store_count = store_count_q;
   assign cycle_count = cycle_count_q;
   assign fail_lane   = fail_lane_q;
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_store_checker.sv
// ----------------------------------------------------------------------------
// tb_store_checker
// Directed and randomized bench for store_checker with a verdict-level
// reference model. Honours STORE_CHECKER_TIMEOUT_EN like the design.
// ----------------------------------------------------------------------------
module tb_store_checker;

   localparam int unsigned NL    = 4;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned TOUT  = 16;
   localparam int unsigned CW    = 6;
   localparam int unsigned CMAX  = (1 << CW) - 1;
`ifdef STORE_CHECKER_TIMEOUT_EN
   localparam bit TOUT_EN = 1'b1;
`else
   localparam bit TOUT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear = 1'b0;
   logic          done, pass, fail, timeout;
   logic [15:0]   store_count;
   logic [CW-1:0] cycle_count;
   logic [1:0]    fail_lane;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;

   store_checker_if #(.NLANES(NL), .AW(AW), .DW(DW)) sif ();

   store_checker #(
      .NLANES(NL), .AW(AW), .DW(DW), .PASS_ADDR(84), .PASS_DATA(7),
      .SCRATCH_ADDR(80), .TIMEOUT(TOUT), .CW(CW)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .st(sif.slave),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .store_count(store_count), .cycle_count(cycle_count),
      .fail_lane(fail_lane), .fail_addr(fail_addr), .fail_data(fail_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: verdict flags, counters and failure capture
   bit m_pass, m_fail, m_tout;
   int unsigned m_sc, m_cc, m_lane, m_addr, m_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pass = 0; m_fail = 0; m_tout = 0;
      m_sc = 0; m_cc = 0; m_lane = 0; m_addr = 0; m_data = 0;
   endtask

   // One sampled cycle: a program-order list of enabled stores, first
   // non-scratch store settles the verdict.
   task automatic model_step();
      int unsigned old_cc, a, d, taken;
      bit decided;
      if (clear) begin
         model_reset();
         return;
      end
      if (m_pass || m_fail || m_tout) return;
      old_cc = m_cc;
      m_cc = (m_cc == CMAX) ? CMAX : m_cc + 1;
      taken = 0;
      decided = 0;
      for (int i = 0; i < NL; i++) begin
         if (!sif.we[i]) continue;
         a = sif.addr[i*AW +: AW];
         d = sif.wdata[i*DW +: DW];
         taken++;
         if (a == 84 && d == 7) begin
            m_pass = 1; decided = 1;
            break;
         end
         if (a != 80) begin
            m_fail = 1; decided = 1;
            m_lane = i; m_addr = a; m_data = d;
            break;
         end
      end
      m_sc = (m_sc + taken > 65535) ? 65535 : m_sc + taken;
      if (!decided && TOUT_EN && old_cc == TOUT - 1) m_tout = 1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".done"}, done, m_pass | m_fail | m_tout);
      check({tag, ".pass"}, pass, m_pass);
      check({tag, ".fail"}, fail, m_fail);
      check({tag, ".timeout"}, timeout, m_tout);
      check({tag, ".store_count"}, store_count, m_sc);
      check({tag, ".cycle_count"}, cycle_count, m_cc);
      check({tag, ".fail_lane"}, fail_lane, m_lane);
      check({tag, ".fail_addr"}, fail_addr, m_addr);
      check({tag, ".fail_data"}, fail_data, m_data);
   endtask

   task automatic set_lane(input int i, input int unsigned a, input int unsigned d);
      sif.addr[i*AW +: AW]  = a;
      sif.wdata[i*DW +: DW] = d;
   endtask

   // Called at a negedge: drive, sample at posedge, check 1 after it
   task automatic cycle(input string tag, input bit clr, input logic [NL-1:0] w);
      clear  = clr;
      sif.we = w;
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
      @(negedge clk);
      clear  = 1'b0;
      sif.we = '0;
   endtask

   // Reset asserted between edges; outputs must clear with no edge seen
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("async_reset");
      clear  = 1'b0;
      sif.we = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int unsigned r;
      sif.we = '0;
      sif.addr = '0;
      sif.wdata = '0;
      model_reset();

      // Scratch then pass in lane 0
      do_reset();
      set_lane(0, 80, 3);
      cycle("t1a", 0, 4'b0001);
      check("t1a.pass_early", pass, 0);
      set_lane(0, 84, 7);
      cycle("t1b", 0, 4'b0001);
      check("t1.pass", pass, 1);
      check("t1.store_count", store_count, 2);

      // Pass in lane 1, lane 2 failure ignored
      do_reset();
      set_lane(1, 84, 7); set_lane(2, 100, 5);
      cycle("t2", 0, 4'b0110);
      check("t2.pass", pass, 1);
      check("t2.store_count", store_count, 1);

      // Failure in lane 2 beats pass in lane 3
      do_reset();
      set_lane(2, 200, 9); set_lane(3, 84, 7);
      cycle("t3", 0, 4'b1100);
      check("t3.fail", fail, 1);
      check("t3.fail_lane", fail_lane, 2);
      check("t3.fail_addr", fail_addr, 200);
      check("t3.fail_data", fail_data, 9);
      check("t3.store_count", store_count, 1);
      set_lane(0, 84, 7);
      cycle("t3_hold", 0, 4'b0001);

      // Wrong data at pass address, then clear with a discarded pass store
      do_reset();
      set_lane(0, 84, 6);
      cycle("t4", 0, 4'b0001);
      check("t4.fail", fail, 1);
      check("t4.fail_addr", fail_addr, 84);
      check("t4.fail_data", fail_data, 6);
      set_lane(0, 84, 7);
      cycle("t4_clear", 1, 4'b0001);
      check("t4_clear.done", done, 0);
      check("t4_clear.store_count", store_count, 0);
      cycle("t4_pass", 0, 4'b0001);
      check("t4_pass.pass", pass, 1);

      // Watchdog and its tie with a lane verdict
      do_reset();
      for (int c = 0; c < TOUT - 1; c++) cycle("wd_idle", 0, '0);
      check("wd.timeout_early", timeout, 0);
      cycle("wd_last", 0, '0);
      check("wd.timeout", timeout, TOUT_EN);
      check("wd.cycle_count", cycle_count, TOUT);
      do_reset();
      for (int c = 0; c < TOUT - 1; c++) cycle("wd2_idle", 0, '0);
      set_lane(0, 84, 7);
      cycle("wd2_pass", 0, 4'b0001);
      check("wd2.pass", pass, 1);
      check("wd2.timeout", timeout, 0);

`ifndef STORE_CHECKER_TIMEOUT_EN
      // Counter saturation (only reachable without the watchdog)
      do_reset();
      for (int c = 0; c < CMAX + 6; c++) cycle("cc_sat", 0, '0);
      check("cc_sat.cycle_count", cycle_count, CMAX);
      do_reset();
      for (int i = 0; i < NL; i++) set_lane(i, 80, i);
      for (int c = 0; c < 16390; c++) cycle("sc_sat", 0, 4'b1111);
      check("sc_sat.store_count", store_count, 16'hFFFF);
`endif

      // Randomized runs, mostly scratch traffic with occasional deciders
      for (int run = 0; run < 40; run++) begin
         do_reset();
         for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < NL; i++) begin
               r = $urandom_range(0, 23);
               if (r == 0)      set_lane(i, 84, ($urandom_range(0, 1) != 0) ? 7 : $urandom_range(0, 9));
               else if (r == 1) set_lane(i, $urandom_range(0, 255), $urandom);
               else             set_lane(i, 80, $urandom);
            end
            cycle("rand", ($urandom_range(0, 19) == 0), 4'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
